pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

Rally/score controller for the Pong datapath, sitting downstream of the ball and upstream of the pixel mux. Once per video frame it checks the ball column against the goal lines, awards points, and holds the ball at centre for a serve delay. It ends the game at a target score and drives a combinational seven-segment score overlay that the top level ORs into R/G/B alongside the paddle and ball draw signals.

## Interface

Parameters:
- WIN_SCORE, 7: points that end the game (1..9).
- SERVE_FRAMES, 60: frames the ball is held at centre before each serve (1..255).
- LEFT_GOAL, 10: ball_x at or below this awards the right player.
- RIGHT_GOAL, 630: ball_x at or above this awards the left player.

Ports:
- clk, in, 1: SYS_CLK domain.
- rst_n, in, 1: asynchronous, active-low reset.
- vsync, in, 1: raw VSYNC from the VGA timing block (active-low pulse, asynchronous to clk).
- ball_x, in, 10: ball left-edge column, stable across frame ticks.
- start_btn, in, 1: raw restart button, active-high, asynchronous.
- pixel_x, in, 10: current pixel column from the VGA timing block.
- pixel_y, in, 10: current pixel row from the VGA timing block.
- serve_hold, out, 1: ball block must park at centre while high.
- serve_dir, out, 1: initial ball direction; 0 = toward left, 1 = toward right.
- left_score, out, 4: left player points.
- right_score, out, 4: right player points.
- game_over, out, 1: high in state OVER.
- winner, out, 1: 0 = left, 1 = right; valid while game_over is high.
- score_draw, out, 1: pixel lies on a lit score-digit segment.

## Operation

- **Input conditioning.**
  - vsync passes through a 2-flop synchronizer plus an edge register.
  - frame_tick is a one-cycle pulse on the synchronized falling edge.
  - start_btn is conditioned the same way, rising edge gives start_pulse.
- **State machine** (states SERVE, PLAY, OVER):
  - **SERVE**: serve_hold = 1. serve_cnt decrements on each frame_tick. On a frame_tick when serve_cnt == 1, go to PLAY with serve_cnt = 0.
  - **PLAY**: serve_hold = 0. Evaluation happens only on frame_tick.
    - ball_x <= LEFT_GOAL: right_score++, serve_dir <= 0 (serve toward the loser).
    - else ball_x >= RIGHT_GOAL: left_score++, serve_dir <= 1.
    - Left-goal check has priority. At most one point is awarded per tick.
    - After a point: if the new score == WIN_SCORE, go to OVER and set winner. Otherwise go to SERVE with serve_cnt = SERVE_FRAMES.
  - **OVER**: serve_hold = 1, game_over = 1, scores frozen. On start_pulse: clear both scores, serve_dir <= 1, serve_cnt = SERVE_FRAMES, go to SERVE. frame_tick is ignored in this state.
- start_pulse in SERVE or PLAY is ignored.
- Scores never exceed WIN_SCORE; increments are saturating as a safety measure.
- **Score overlay.**
  - Left digit box: x 280..299, y 20..51. Right digit box: x 340..359, same y range.
  - Local coordinates are pixel minus box origin. Segments are 4 px thick on a 20x32 cell, standard a–g mapping.
  - score_draw = (in left box & left glyph lit) | (in right box & right glyph lit).
  - Score values 10..15 never occur; they render blank.

## Timing

- **Reset values**: state SERVE, serve_cnt = SERVE_FRAMES, scores 0, serve_dir 1, winner 0, game_over 0, serve_hold 1, all synchronizer/edge flops 0. score_draw then reflects the "0 0" digits.
- **vsync to frame_tick**: frame_tick asserts 3 clk cycles after vsync falls (2 sync + 1 edge).
- **Register updates**: state, scores, serve_dir and winner update on the edge after frame_tick. serve_hold, game_over and the score outputs follow state and score registers with no extra delay.
- **score_draw**: purely combinational from pixel_x/y and the score registers, zero latency. Matches the paddle draw path.
- **Reset mid-game**: asynchronous return to the reset values, with no partial point awarded.

## Structure

- **pong_pkg**: holds shared constants and types.
  - State enum: SERVE, PLAY, OVER.
  - Screen constants: 640x480, digit box origins and sizes, segment thickness.
  - Seven-segment decode function (4-bit digit to 7-bit a–g).
- **seven_seg_glyph** (sub-module, instantiated twice): inputs digit[3:0], lx[4:0], ly[4:0]; output on. Purely combinational.
- The top module contains the synchronizers, FSM, serve counter and score registers.

## Test plan

- **Reset, SERVE_FRAMES=3**: rst_n low then high, 3 vsync falls → serve_hold drops on the 3rd tick +1 cycle, state PLAY, scores 0/0.
- **Right point**: PLAY, ball_x = 5, one vsync → right_score = 1, serve_dir = 0, serve_hold = 1, frame_tick observed exactly 3 cycles after vsync falls.
- **Game end, WIN_SCORE=2**: left scores twice (ball_x = 635) → game_over = 1, winner = 0. Further vsyncs with ball_x = 5 leave scores at 2/0. start_btn rise → scores 0/0, state SERVE, serve_dir = 1.
- **Ignored events**: ball_x = 0 held during SERVE → no point. start_btn during PLAY → no effect.
- **Overlay**: left_score = 1 → pixel (296, 24) draws and pixel (282, 24) does not. Right score 0 → pixel (341, 30) draws and pixel (349, 35) does not.
- **Async reset mid-PLAY** with left_score = 3, asserted between clk edges → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, screen geometry and helpers for the Pong score keeper.
// Glyph geometry is expressed in 5-bit cell-local coordinates.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_e;

    localparam logic [9:0] SCREEN_W = 10'd640;
    localparam logic [9:0] SCREEN_H = 10'd480;

    localparam logic [9:0] L_BOX_X = 10'd280;
    localparam logic [9:0] R_BOX_X = 10'd340;
    localparam logic [9:0] BOX_Y   = 10'd20;
    localparam logic [9:0] BOX_W   = 10'd20;
    localparam logic [9:0] BOX_H   = 10'd32;

    // Cell is 20x32; segments are SEG_T thick, middle bar sits around row 16.
    localparam logic [4:0] SEG_T  = 5'd4;
    localparam logic [4:0] CELL_W = 5'd20;
    localparam logic [4:0] HALF_H = 5'd16;
    localparam logic [4:0] MID_LO = 5'd14;
    localparam logic [4:0] BOT_Y  = 5'd28;

    // Returns {a,b,c,d,e,f,g}; digits above 9 render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value < limit) ? (value + 4'd1) : limit;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational seven-segment glyph: is cell-local pixel (lx, ly) on a lit segment of digit.
module seven_seg_glyph
    import pong_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [4:0] lx,
    input  logic [4:0] ly,
    output logic       on
);

    logic [6:0] w_seg;
    logic       w_left_col;
    logic       w_right_col;
    logic       w_upper;
    logic       w_seg_a;
    logic       w_seg_d;
    logic       w_seg_g;

    assign w_seg       = seg_decode(digit);
    assign w_left_col  = (lx < SEG_T);
    assign w_right_col = (lx >= (CELL_W - SEG_T));
    assign w_upper     = (ly < HALF_H);
    assign w_seg_a     = (ly < SEG_T);
    assign w_seg_d     = (ly >= BOT_Y);
    assign w_seg_g     = (ly >= MID_LO) && (ly < (MID_LO + SEG_T));

    assign on = (w_seg[6] & w_seg_a)
              | (w_seg[5] & w_right_col & w_upper)
              | (w_seg[4] & w_right_col & ~w_upper)
              | (w_seg[3] & w_seg_d)
              | (w_seg[2] & w_left_col & ~w_upper)
              | (w_seg[1] & w_left_col & w_upper)
              | (w_seg[0] & w_seg_g);

endmodule

// File: rtl/pong_score_keeper.sv
// Per-frame rally/score controller with serve delay, game-over latch and a
// combinational two-digit score overlay.
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int LEFT_GOAL    = 10,
    parameter int RIGHT_GOAL   = 630
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic [9:0] ball_x,
    input  logic       start_btn,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       serve_hold,
    output logic       serve_dir,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       game_over,
    output logic       winner,
    output logic       score_draw
);

    localparam logic [3:0] WIN_C   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_C = 8'(SERVE_FRAMES);
    localparam logic [9:0] LEFT_C  = 10'(LEFT_GOAL);
    localparam logic [9:0] RIGHT_C = 10'(RIGHT_GOAL);

    logic   r_vs_s1, r_vs_s2, r_vs_prev, r_frame_tick;
    logic   r_st_s1, r_st_s2, r_st_prev, r_start_pulse;
    state_e r_state, w_state_nxt;
    logic [7:0] r_serve_cnt, w_cnt_nxt;
    logic [3:0] r_left, w_left_nxt, w_left_inc;
    logic [3:0] r_right, w_right_nxt, w_right_inc;
    logic   r_dir, w_dir_nxt;
    logic   r_winner, w_winner_nxt;
    logic   r_serve_hold, r_game_over;

    // Synchronize vsync/start_btn and register their edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_s1       <= 1'b0;
            r_vs_s2       <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_st_s1       <= 1'b0;
            r_st_s2       <= 1'b0;
            r_st_prev     <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_vs_s1       <= vsync;
            r_vs_s2       <= r_vs_s1;
            r_vs_prev     <= r_vs_s2;
            r_frame_tick  <= r_vs_prev & ~r_vs_s2;
            r_st_s1       <= start_btn;
            r_st_s2       <= r_st_s1;
            r_st_prev     <= r_st_s2;
            r_start_pulse <= r_st_s2 & ~r_st_prev;
        end
    end

    assign w_left_inc  = sat_inc(r_left, WIN_C);
    assign w_right_inc = sat_inc(r_right, WIN_C);

    // Next-state and next-score logic; only frame ticks and start pulses move the game.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_serve_cnt;
        w_left_nxt   = r_left;
        w_right_nxt  = r_right;
        w_dir_nxt    = r_dir;
        w_winner_nxt = r_winner;
        case (r_state)
            SERVE: begin
                if (r_frame_tick) begin
                    if (r_serve_cnt <= 8'd1) begin
                        w_state_nxt = PLAY;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_serve_cnt - 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_serve_cnt;
                end
            end
            PLAY: begin
                // Left goal wins ties so at most one point is awarded per frame.
                if (r_frame_tick) begin
                    if (ball_x <= LEFT_C) begin
                        w_right_nxt = w_right_inc;
                        w_dir_nxt   = 1'b0;
                        if (w_right_inc == WIN_C) begin
                            w_state_nxt  = OVER;
                            w_winner_nxt = 1'b1;
                        end else begin
                            w_state_nxt = SERVE;
                            w_cnt_nxt   = SERVE_C;
                        end
                    end else if (ball_x >= RIGHT_C) begin
                        w_left_nxt = w_left_inc;
                        w_dir_nxt  = 1'b1;
                        if (w_left_inc == WIN_C) begin
                            w_state_nxt  = OVER;
                            w_winner_nxt = 1'b0;
                        end else begin
                            w_state_nxt = SERVE;
                            w_cnt_nxt   = SERVE_C;
                        end
                    end else begin
                        w_state_nxt = PLAY;
                    end
                end else begin
                    w_state_nxt = PLAY;
                end
            end
            OVER: begin
                if (r_start_pulse) begin
                    w_state_nxt = SERVE;
                    w_cnt_nxt   = SERVE_C;
                    w_left_nxt  = 4'd0;
                    w_right_nxt = 4'd0;
                    w_dir_nxt   = 1'b1;
                end else begin
                    w_state_nxt = OVER;
                end
            end
            default: begin
                w_state_nxt = SERVE;
                w_cnt_nxt   = SERVE_C;
            end
        endcase
    end

    // Game state, scores and the state-derived flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SERVE;
            r_serve_cnt  <= SERVE_C;
            r_left       <= 4'd0;
            r_right      <= 4'd0;
            r_dir        <= 1'b1;
            r_winner     <= 1'b0;
            r_serve_hold <= 1'b1;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_serve_cnt  <= w_cnt_nxt;
            r_left       <= w_left_nxt;
            r_right      <= w_right_nxt;
            r_dir        <= w_dir_nxt;
            r_winner     <= w_winner_nxt;
            r_serve_hold <= (w_state_nxt != PLAY);
            r_game_over  <= (w_state_nxt == OVER);
        end
    end

    assign serve_hold  = r_serve_hold;
    assign serve_dir   = r_dir;
    assign left_score  = r_left;
    assign right_score = r_right;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

    logic       w_in_y, w_in_left, w_in_right;
    logic [4:0] w_left_lx, w_right_lx, w_ly;
    logic       w_left_on, w_right_on;

    assign w_in_y     = (pixel_y >= BOX_Y) && (pixel_y < (BOX_Y + BOX_H));
    assign w_in_left  = w_in_y && (pixel_x >= L_BOX_X) && (pixel_x < (L_BOX_X + BOX_W));
    assign w_in_right = w_in_y && (pixel_x >= R_BOX_X) && (pixel_x < (R_BOX_X + BOX_W));
    assign w_left_lx  = 5'(pixel_x - L_BOX_X);
    assign w_right_lx = 5'(pixel_x - R_BOX_X);
    assign w_ly       = 5'(pixel_y - BOX_Y);

    seven_seg_glyph u_left_glyph (
        .digit (r_left),
        .lx    (w_left_lx),
        .ly    (w_ly),
        .on    (w_left_on)
    );

    seven_seg_glyph u_right_glyph (
        .digit (r_right),
        .lx    (w_right_lx),
        .ly    (w_ly),
        .on    (w_right_on)
    );

    assign score_draw = (w_in_left & w_left_on) | (w_in_right & w_right_on);

endmodule

// File: tb/tb_pong_score_keeper.sv
// Scoreboard bench for pong_score_keeper (SERVE_FRAMES=3, WIN_SCORE=4).
module tb_pong_score_keeper;

    localparam int SF = 3;
    localparam int WS = 4;
    localparam int LG = 10;
    localparam int RG = 630;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       vsync     = 1'b1;
    logic [9:0] ball_x    = 10'd320;
    logic       start_btn = 1'b0;
    logic [9:0] pixel_x   = 10'd0;
    logic [9:0] pixel_y   = 10'd0;
    logic       serve_hold, serve_dir, game_over, winner, score_draw;
    logic [3:0] left_score, right_score;

    pong_score_keeper #(
        .WIN_SCORE    (WS),
        .SERVE_FRAMES (SF),
        .LEFT_GOAL    (LG),
        .RIGHT_GOAL   (RG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .ball_x      (ball_x),
        .start_btn   (start_btn),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .serve_hold  (serve_hold),
        .serve_dir   (serve_dir),
        .left_score  (left_score),
        .right_score (right_score),
        .game_over   (game_over),
        .winner      (winner),
        .score_draw  (score_draw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] l;
        logic [3:0] r;
        logic       hold;
        logic       dir;
        logic       over;
        logic       win;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: 0 = serve, 1 = play, 2 = over
    int         m_state;
    int         m_cnt;
    logic [3:0] m_left, m_right;
    logic       m_dir, m_win;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.l    = m_left;
        e.r    = m_right;
        e.hold = (m_state != 1);
        e.dir  = m_dir;
        e.over = (m_state == 2);
        e.win  = m_win;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = SF;
        m_left  = 4'd0;
        m_right = 4'd0;
        m_dir   = 1'b1;
        m_win   = 1'b0;
    endtask

    task automatic model_frame(input int bx);
        if (m_state == 0) begin
            if (m_cnt == 1) begin
                m_state = 1;
                m_cnt   = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (m_state == 1) begin
            if (bx <= LG) begin
                if (m_right < WS) m_right = m_right + 4'd1;
                m_dir = 1'b0;
                if (m_right == WS) begin m_state = 2; m_win = 1'b1; end
                else begin m_state = 0; m_cnt = SF; end
            end else if (bx >= RG) begin
                if (m_left < WS) m_left = m_left + 4'd1;
                m_dir = 1'b1;
                if (m_left == WS) begin m_state = 2; m_win = 1'b0; end
                else begin m_state = 0; m_cnt = SF; end
            end
        end
        exp_q.push_back(cur_exp());
    endtask

    task automatic model_start();
        if (m_state == 2) begin
            m_state = 0;
            m_cnt   = SF;
            m_left  = 4'd0;
            m_right = 4'd0;
            m_dir   = 1'b1;
        end
        exp_q.push_back(cur_exp());
    endtask

    task automatic check_now(input string tag, input exp_t e);
        check({tag, "_left"},  left_score,  e.l);
        check({tag, "_right"}, right_score, e.r);
        check({tag, "_hold"},  serve_hold,  e.hold);
        check({tag, "_dir"},   serve_dir,   e.dir);
        check({tag, "_over"},  game_over,   e.over);
        if (e.over) check({tag, "_winner"}, winner, e.win);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_sb_size"}, exp_q.size(), 1);
        if (exp_q.size() > 0) check_now(tag, exp_q.pop_front());
    endtask

    // vsync falls mid-cycle; outputs must hold for 3 edges and update on the 4th.
    task automatic do_frame(input int bx);
        exp_t old;
        ball_x = 10'(bx);
        old = cur_exp();
        model_frame(bx);
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check_now("frame_early", old);
        @(negedge clk);
        pop_check("frame");
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_start();
        exp_t old;
        old = cur_exp();
        model_start();
        @(negedge clk);
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        check_now("start_early", old);
        @(negedge clk);
        pop_check("start");
        start_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic serve_out();
        for (int i = 0; i < SF; i++) do_frame(320);
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic exp);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        check(tag, score_draw, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_now("reset", cur_exp());
        check("reset_winner", winner, 1'b0);
        check_pix("pix_rst_r0_on", 341, 30, 1'b1);
        check_pix("pix_rst_r0_hole", 349, 35, 1'b0);
        check_pix("pix_rst_l0_f", 282, 24, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Serve period with ball parked in the goal: no point may be awarded
        for (int i = 0; i < SF; i++) do_frame(0);
        do_start();

        do_frame(635);
        check_pix("pix_l1_b", 296, 24, 1'b1);
        check_pix("pix_l1_f_off", 282, 24, 1'b0);
        check_pix("pix_r0_on", 341, 30, 1'b1);
        check_pix("pix_r0_hole", 349, 35, 1'b0);
        check_pix("pix_outside_l", 300, 24, 1'b0);
        check_pix("pix_above_box", 296, 19, 1'b0);
        check_pix("pix_r0_bottom", 350, 51, 1'b1);
        check_pix("pix_below_box", 350, 52, 1'b0);

        serve_out();
        do_frame(5);
        serve_out();
        do_frame(320);
        do_frame(630);
        serve_out();
        do_frame(635);
        serve_out();
        check("pre_rst_left", left_score, 4'd3);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async_rst", cur_exp());
        check("async_rst_winner", winner, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        serve_out();
        do_frame(11);
        do_frame(629);
        do_frame(10);
        serve_out();
        for (int i = 0; i < WS; i++) begin
            do_frame(630);
            if (m_state == 0) serve_out();
        end
        do_frame(5);
        do_frame(0);
        check("over_left", left_score, 4'd4);

        do_start();
        serve_out();
        for (int i = 0; i < WS; i++) begin
            do_frame(0);
            if (m_state == 0) serve_out();
        end
        do_frame(635);
        do_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
